// File: rtl/alu16_ctrl.sv
// -----------------------------------------------------------------------------
// alu16_ctrl -- sequencer for a 16-bit shift/add datapath (A, Q, Q[-1], M).
//
// Drives the register commands that carry out add, subtract, Booth radix-2
// multiply and non-restoring divide on an external datapath. A is 17 bits wide
// (A[16] is the sign bit fed back as a_sign); Q[0] and Q[-1] are fed back for
// the Booth recoding.
//
// Ports
//   clk      rising-edge clock
//   rst_b    asynchronous active-low reset
//   start    operation request, sampled only in IDLE
//   op       00 add, 01 sub, 10 mul, 11 div (latched on acceptance)
//   q0       Q[0] from the datapath
//   q_m1     Q[-1] from the datapath
//   a_sign   A[16] from the datapath
//   a_sel    A command: 00 hold, 01 asr, 10 shl (Q[15] enters), 11 load
//   q_sel    Q command, same encoding as a_sel
//   a_clr    A load source is zero (INIT only) instead of the X operand
//   alu_sub  adder mode for A loads outside INIT: 1 = A-M, 0 = A+M
//   m_load   load M from the Y operand
//   qm1_clr  clear Q[-1]
//   q_set    write q_bit into Q[0]
//   q_bit    quotient bit value
//   busy     high from INIT up to the state before DONE
//   done     one-cycle completion pulse
//   cnt      iteration counter
//
// The command outputs are decoded from the current state (and, in M_CHECK,
// D_ADDSUB, D_SETQ and D_CORR, from the datapath feedback bits) so each command
// takes effect on the clock edge that leaves the state issuing it.
// -----------------------------------------------------------------------------
module alu16_ctrl (
  input  logic       clk,
  input  logic       rst_b,
  input  logic       start,
  input  logic [1:0] op,
  input  logic       q0,
  input  logic       q_m1,
  input  logic       a_sign,
  output logic [1:0] a_sel,
  output logic [1:0] q_sel,
  output logic       a_clr,
  output logic       alu_sub,
  output logic       m_load,
  output logic       qm1_clr,
  output logic       q_set,
  output logic       q_bit,
  output logic       busy,
  output logic       done,
  output logic [3:0] cnt
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_INIT,
    S_EXEC,
    S_M_CHECK,
    S_M_SHIFT,
    S_D_SHIFT,
    S_D_ADDSUB,
    S_D_SETQ,
    S_D_CORR,
    S_DONE
  } state_t;

  localparam logic [1:0] SEL_HOLD = 2'b00;
  localparam logic [1:0] SEL_ASR  = 2'b01;
  localparam logic [1:0] SEL_SHL  = 2'b10;
  localparam logic [1:0] SEL_LOAD = 2'b11;
  localparam logic [1:0] OP_MUL   = 2'b10;
  localparam logic [3:0] CNT_LAST = 4'd15;

  state_t     r_state;
  logic [1:0] r_op;
  logic [3:0] r_cnt;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state <= S_IDLE;
      r_op    <= 2'b00;
      r_cnt   <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op    <= op;
            r_state <= S_INIT;
          end
        end
        S_INIT: begin
          if (r_op[1]) begin
            r_cnt   <= 4'd0;
            r_state <= (r_op == OP_MUL) ? S_M_CHECK : S_D_SHIFT;
          end else begin
            r_state <= S_EXEC;
          end
        end
        S_EXEC:    r_state <= S_DONE;
        S_M_CHECK: r_state <= S_M_SHIFT;
        S_M_SHIFT: begin
          // 4-bit counter wraps to 0 on the sixteenth increment.
          r_cnt   <= r_cnt + 4'd1;
          r_state <= (r_cnt == CNT_LAST) ? S_DONE : S_M_CHECK;
        end
        S_D_SHIFT:  r_state <= S_D_ADDSUB;
        S_D_ADDSUB: r_state <= S_D_SETQ;
        S_D_SETQ: begin
          r_cnt   <= r_cnt + 4'd1;
          r_state <= (r_cnt == CNT_LAST) ? S_D_CORR : S_D_SHIFT;
        end
        S_D_CORR: r_state <= S_DONE;
        S_DONE:   r_state <= S_IDLE;   // start is deliberately not sampled here
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  assign cnt = r_cnt;

  // NOTE: every output gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    a_sel   = SEL_HOLD;
    q_sel   = SEL_HOLD;
    a_clr   = 1'b0;
    alu_sub = 1'b0;
    m_load  = 1'b0;
    qm1_clr = 1'b0;
    q_set   = 1'b0;
    q_bit   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (r_state)
      S_INIT: begin
        busy   = 1'b1;
        m_load = 1'b1;
        a_sel  = SEL_LOAD;
        if (r_op[1]) begin
          // mul/div start from A=0, Q=X, Q[-1]=0
          a_clr   = 1'b1;
          q_sel   = SEL_LOAD;
          qm1_clr = 1'b1;
        end
      end
      S_EXEC: begin
        busy    = 1'b1;
        a_sel   = SEL_LOAD;
        alu_sub = r_op[0];
      end
      S_M_CHECK: begin
        busy = 1'b1;
        // Booth recoding: 10 -> A-M, 01 -> A+M, 00/11 -> no add
        case ({q0, q_m1})
          2'b10: begin
            a_sel   = SEL_LOAD;
            alu_sub = 1'b1;
          end
          2'b01:   a_sel = SEL_LOAD;
          default: a_sel = SEL_HOLD;
        endcase
      end
      S_M_SHIFT: begin
        busy  = 1'b1;
        a_sel = SEL_ASR;
        q_sel = SEL_ASR;
      end
      S_D_SHIFT: begin
        busy  = 1'b1;
        a_sel = SEL_SHL;
        q_sel = SEL_SHL;
      end
      S_D_ADDSUB: begin
        busy    = 1'b1;
        a_sel   = SEL_LOAD;
        alu_sub = ~a_sign;   // subtract while the partial remainder is >= 0
      end
      S_D_SETQ: begin
        busy  = 1'b1;
        q_set = 1'b1;
        q_bit = ~a_sign;
      end
      S_D_CORR: begin
        busy = 1'b1;
        // a negative final remainder is restored by adding M back once
        if (a_sign) a_sel = SEL_LOAD;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/alu16_ctrl.md
ALU16_CTRL -- requirements
Module: alu16_ctrl

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 rst_b  input  1  asynchronous, active-low reset.
REQ-003 start  input  1  operation request, sampled only in IDLE.
REQ-004 op  input  2  00 add, 01 sub, 10 mul (Booth radix-2), 11 div (non-restoring); latched when start is accepted.
REQ-005 q0  input  1  Q register bit 0 (Booth LSB).
REQ-006 q_m1  input  1  Booth extra bit Q[-1].
REQ-007 a_sign  input  1  A register bit 16 (sign of the partial remainder or sum).
REQ-008 a_sel  output  2  A register command: 00 hold, 01 arithmetic shift right, 10 shift left (Q[15] enters), 11 load.
REQ-009 q_sel  output  2  Q register command, same encoding as a_sel.
REQ-010 a_clr  output  1  selects zero as the A load source for a_sel=11 in INIT; otherwise the X operand is the source.
REQ-011 alu_sub  output  1  adder mode: 1 = A-M, 0 = A+M; only meaningful while a_sel=11 outside INIT.
REQ-012 m_load  output  1  loads the M register from the Y operand.
REQ-013 qm1_clr  output  1  clears Q[-1].
REQ-014 q_set  output  1  writes q_bit into Q[0].
REQ-015 q_bit  output  1  quotient bit value.
REQ-016 busy  output  1  high from INIT through the last state before DONE.
REQ-017 done  output  1  one-cycle completion pulse.
REQ-018 cnt  output  4  iteration counter.

Function
REQ-019 States SHALL be IDLE, INIT, EXEC, M_CHECK, M_SHIFT, D_SHIFT, D_ADDSUB, D_SETQ, D_CORR and DONE; every command output not stated for a state SHALL be 0.
REQ-020 IDLE: when start=1, op SHALL be latched and the next state SHALL be INIT; otherwise the block SHALL stay in IDLE.
REQ-021 INIT: m_load=1, busy=1 and a_sel=11 SHALL be driven in INIT for every op.
REQ-022 INIT for add/sub: a_clr=0, with next state EXEC.
REQ-023 INIT for mul/div: a_clr=1, q_sel=11 and qm1_clr=1, with cnt cleared to 0.
REQ-024 INIT for mul/div: the next state SHALL be M_CHECK for mul and D_SHIFT for div.
REQ-025 EXEC: a_sel=11 and alu_sub=op[0], with next state DONE.
REQ-026 M_CHECK: {q0,q_m1}=10 SHALL drive a_sel=11 with alu_sub=1, 01 SHALL drive a_sel=11 with alu_sub=0, and 00 or 11 SHALL drive a_sel=00; next state M_SHIFT.
REQ-027 M_SHIFT: a_sel=01 and q_sel=01; cnt SHALL increment; the next state SHALL be DONE if cnt was 15, else M_CHECK.
REQ-028 D_SHIFT: a_sel=10 and q_sel=10, with next state D_ADDSUB.
REQ-029 D_ADDSUB: a_sel=11 and alu_sub=~a_sign (subtract when A>=0), with next state D_SETQ.
REQ-030 D_SETQ: q_set=1 and q_bit=~a_sign; cnt SHALL increment; the next state SHALL be D_CORR if cnt was 15, else D_SHIFT.
REQ-031 D_CORR: if a_sign=1, a_sel=11 and alu_sub=0 (remainder restore); otherwise a_sel=00; next state DONE.
REQ-032 DONE: done=1 and busy=0 for exactly one cycle, then IDLE; start asserted in DONE SHALL be ignored.
REQ-033 Latency, counting the start-sampling edge as cycle 0: done SHALL be high in cycle 3 for add/sub, cycle 34 for mul and cycle 51 for div.
REQ-034 cnt SHALL wrap from 15 to 0 on the final increment; start and op changes while busy SHALL be ignored.

Reset
REQ-035 rst_b=0 SHALL immediately, without waiting for clk, force IDLE, cnt=0 and all outputs to 0, including mid-operation.
REQ-036 After rst_b rises, the first start SHALL be accepted normally.

Verification
REQ-037 op=00, start pulse: INIT a_sel=11 a_clr=0 m_load=1 -> EXEC a_sel=11 alu_sub=0 -> done in cycle 3.
REQ-038 op=10, q0/q_m1 model from X=0x0003 and Y=0x0005: first M_CHECK a_sel=11 alu_sub=1, last M_SHIFT cnt 15->0, done in cycle 34, A:Q = 15.
REQ-039 op=11, X=100 and Y=7 using the bench A/Q/M model: 16 D_SETQ pulses, done in cycle 51, Q=14, A=2; D_CORR restore occurs only if final a_sign=1.
REQ-040 Reset mid-division (cnt=7): all outputs are 0 and the state is IDLE asynchronously; a new op=01 then completes in 3 cycles with alu_sub=1.
REQ-041 start held high through DONE: exactly one operation per IDLE acceptance, done never high for two consecutive cycles, busy=0 whenever done=1.
